// File: rtl/memory_stage_sequencer.sv
// -----------------------------------------------------------------------------
// memory_stage_sequencer
//
// Purpose: pipeline memory stage in front of memoryController. It takes one
// operation at a time from the execute stage, checks its alignment and length,
// and drives the controller's request strobes for the right number of cycles.
// It then returns a one-cycle writeback pulse to the register-file stage.
//
// Ports:
//   clk, reset            - clock; synchronous active-high reset
//   exValid / exReady     - execute-stage handshake (exReady is combinational)
//   exAddress, exData,
//   exLength, exLoad,
//   exStore, exUnsigned,
//   exRd                  - operation fields, captured on the accept edge
//   addressIn, dataWriteIn,
//   length, loadIn,
//   storeIn, loadUnsighed - request to memoryController
//   dataReadOut           - load data returned by memoryController
//   wbValid, wbRd,
//   wbData, wbFault       - registered writeback pulse
// -----------------------------------------------------------------------------
module memory_stage_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      exValid,
  output logic                      exReady,
  input  logic [DATA_WIDTH-1:0]     exAddress,
  input  logic [DATA_WIDTH-1:0]     exData,
  input  logic [DATA_WIDTH-1:0]     exLength,
  input  logic                      exLoad,
  input  logic                      exStore,
  input  logic                      exUnsigned,
  input  logic [REG_ADDR_WIDTH-1:0] exRd,
  output logic [DATA_WIDTH-1:0]     addressIn,
  output logic [DATA_WIDTH-1:0]     dataWriteIn,
  output logic [DATA_WIDTH-1:0]     length,
  output logic                      loadIn,
  output logic                      storeIn,
  output logic                      loadUnsighed,
  input  logic [DATA_WIDTH-1:0]     dataReadOut,
  output logic                      wbValid,
  output logic [REG_ADDR_WIDTH-1:0] wbRd,
  output logic [DATA_WIDTH-1:0]     wbData,
  output logic                      wbFault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  // Counter value on the final LOAD cycle (counter starts at 0).
  localparam logic [3:0] LAST_CNT = 4'(LOAD_LATENCY - 1);

  localparam logic [DATA_WIDTH-1:0] LEN_1 = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] LEN_2 = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] LEN_4 = DATA_WIDTH'(4);

  localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]     D_ZERO  = {DATA_WIDTH{1'b0}};

  logic [1:0]                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     len_q, len_d;
  logic                      uns_q, uns_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      wb_fault_q, wb_fault_d;

  logic accept_s;
  logic len_bad_s;
  logic misalign_s;
  logic fault_s;

  assign exReady  = (state_q == S_IDLE) && !reset;
  assign accept_s = exValid && exReady;

  // Fault classification is done on the live inputs at the accept edge so the
  // fault/pass-through writeback can be issued the very next cycle.
  assign len_bad_s  = (exLength != LEN_1) && (exLength != LEN_2) && (exLength != LEN_4);
  assign misalign_s = ((exLength == LEN_2) && exAddress[0]) ||
                      ((exLength == LEN_4) && (exAddress[1:0] != 2'b00));
  assign fault_s    = (exLoad && exStore) || len_bad_s || misalign_s;

  // Next-state, capture and writeback logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_fault_d = wb_fault_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d  = exAddress;
          wdata_d = exData;
          len_d   = exLength;
          uns_d   = exUnsigned;
          rd_d    = exRd;
          cnt_d   = 4'd0;
          if (fault_s) begin
            wb_valid_d = 1'b1;
            wb_fault_d = 1'b1;
            wb_rd_d    = RD_ZERO;
            wb_data_d  = exAddress;
          end else if (!exLoad && !exStore) begin
            wb_valid_d = 1'b1;
            wb_fault_d = 1'b0;
            wb_rd_d    = exRd;
            wb_data_d  = exData;
          end else if (exStore) begin
            state_d = S_STORE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        state_d    = S_IDLE;
        wb_valid_d = 1'b1;
        wb_fault_d = 1'b0;
        wb_rd_d    = RD_ZERO;
        wb_data_d  = wdata_q;
      end
      S_LOAD: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = S_IDLE;
          cnt_d      = 4'd0;
          wb_valid_d = 1'b1;
          wb_fault_d = 1'b0;
          wb_rd_d    = rd_q;
          wb_data_d  = dataReadOut;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= D_ZERO;
      wdata_q    <= D_ZERO;
      len_q      <= D_ZERO;
      uns_q      <= 1'b0;
      rd_q       <= RD_ZERO;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= RD_ZERO;
      wb_data_q  <= D_ZERO;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  assign addressIn    = addr_q;
  assign dataWriteIn  = wdata_q;
  assign length       = len_q;
  assign loadUnsighed = uns_q;
  assign loadIn       = (state_q == S_LOAD);
  assign storeIn      = (state_q == S_STORE);
  assign wbValid      = wb_valid_q;
  assign wbRd         = wb_rd_q;
  assign wbData       = wb_data_q;
  assign wbFault      = wb_fault_q;

endmodule

// File: tb/tb_memory_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_memory_stage_sequencer
//
// Purpose: self-checking bench for memory_stage_sequencer. A driver issues
// directed and random operations and pushes the expected writeback into a
// scoreboard queue. A monitor on the falling edge checks every writeback
// pulse, the request strobes, exReady and the held request fields.
// -----------------------------------------------------------------------------
module tb_memory_stage_sequencer;

  localparam int LL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        exValid;
  logic        exReady;
  logic [31:0] exAddress, exData, exLength;
  logic        exLoad, exStore, exUnsigned;
  logic [4:0]  exRd;
  logic [31:0] addressIn, dataWriteIn, length;
  logic        loadIn, storeIn, loadUnsighed;
  logic [31:0] dataReadOut;
  logic        wbValid;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        wbFault;

  memory_stage_sequencer #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_LATENCY(LL)
  ) dut (
    .clk(clk), .reset(reset), .exValid(exValid), .exReady(exReady),
    .exAddress(exAddress), .exData(exData), .exLength(exLength),
    .exLoad(exLoad), .exStore(exStore), .exUnsigned(exUnsigned), .exRd(exRd),
    .addressIn(addressIn), .dataWriteIn(dataWriteIn), .length(length),
    .loadIn(loadIn), .storeIn(storeIn), .loadUnsighed(loadUnsighed),
    .dataReadOut(dataReadOut), .wbValid(wbValid), .wbRd(wbRd),
    .wbData(wbData), .wbFault(wbFault)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; "interval c" is the time after edge c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fault;
    logic        chk_data;
  } wb_t;

  wb_t sb[$];
  wb_t me;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;
  bit done    = 1'b0;

  // Expected request-side state, maintained by the driver.
  int          load_from = -10, load_to = -11, store_at = -10;
  logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0, exp_len = 32'd0;
  logic        exp_uns = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference rule for a faulting request.
  function automatic bit model_fault(bit ld, bit st, logic [31:0] addr, logic [31:0] len);
    bit len_ok;
    len_ok = (len == 32'd1) || (len == 32'd2) || (len == 32'd4);
    return (ld && st) || !len_ok || (len == 32'd2 && addr % 2 != 0) ||
           (len == 32'd4 && addr % 4 != 0);
  endfunction

  // Monitor: strobes, ready, held fields and the writeback scoreboard.
  always @(negedge clk) begin
    if (mon_en && !done) begin
      chk("loadIn", {31'd0, loadIn}, {31'd0, (cyc >= load_from && cyc <= load_to)});
      chk("storeIn", {31'd0, storeIn}, {31'd0, (cyc == store_at)});
      chk("exReady", {31'd0, exReady},
          {31'd0, (!reset && !(cyc >= load_from && cyc <= load_to) && cyc != store_at)});
      chk("req_fields", addressIn ^ dataWriteIn ^ {length[30:0], loadUnsighed},
          exp_addr ^ exp_wdata ^ {exp_len[30:0], exp_uns});
      chk("addressIn", addressIn, exp_addr);
      if (wbValid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL wb_unexpected: wbValid=1 with nothing expected (cycle %0d)", cyc);
        end else begin
          me = sb.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(me.cyc));
          chk("wb_rd", {27'd0, wbRd}, {27'd0, me.rd});
          chk("wb_fault", {31'd0, wbFault}, {31'd0, me.fault});
          if (me.chk_data) chk("wb_data", wbData, me.data);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        n_total++;
        $display("FAIL wb_missing: got no wbValid, expected one at cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Present one operation, wait for acceptance, then play the memory side.
  // rst_k >= 0 asserts reset in that LOAD cycle (0-based) and returns.
  task automatic issue(input bit ld, input bit st, input bit uns, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] len, input logic [4:0] rd,
                       input logic [31:0] rdata, input int rst_k);
    bit  ready;
    bit  flt;
    int  n;
    int  a;
    wb_t e;
    exValid = 1'b1; exLoad = ld; exStore = st; exUnsigned = uns;
    exAddress = addr; exData = data; exLength = len; exRd = rd;
    ready = 1'b0; n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      if (exReady) ready = 1'b1;
      else n++;
    end
    if (!ready) begin
      n_total++;
      $display("FAIL accept_timeout: got exReady=0 for 50 cycles, expected 1");
      exValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a   = cyc;
    flt = model_fault(ld, st, addr, len);
    e.fault    = flt;
    e.rd       = (flt || st) ? 5'd0 : rd;
    e.data     = flt ? addr : (ld ? rdata : data);
    e.chk_data = flt || !st;
    if (flt || (!ld && !st)) e.cyc = a;
    else if (st)             e.cyc = a + 1;
    else                     e.cyc = a + LL;
    sb.push_back(e);
    exp_addr = addr; exp_wdata = data; exp_len = len; exp_uns = uns;
    if (!flt && st) store_at = a;
    if (!flt && ld) begin load_from = a; load_to = a + LL - 1; end
    // Scramble the inputs: the DUT must work from its captured copy.
    exValid = 1'b0; exAddress = $urandom; exData = $urandom; exLength = $urandom;
    exRd = 5'($urandom); exUnsigned = 1'($urandom);
    if (!flt && ld) begin
      for (int k = 0; k < LL; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (k == rst_k) begin
          reset = 1'b1;
          load_to = cyc;
          for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > cyc) sb.delete(i);
          return;
        end
        dataReadOut = (k == LL - 1) ? rdata : ~rdata;
      end
      @(posedge clk); #1;
      dataReadOut = $urandom;
    end else if (!flt && st) begin
      @(posedge clk); #1;
    end
  endtask

  // Complete a reset that is already asserted and check reset values.
  task automatic finish_reset();
    @(posedge clk); #1;
    exp_addr = 32'd0; exp_wdata = 32'd0; exp_len = 32'd0; exp_uns = 1'b0;
    @(negedge clk);
    chk("rst_wbValid", {31'd0, wbValid}, 32'd0);
    chk("rst_wbData", wbData, 32'd0);
    chk("rst_wbRd", {27'd0, wbRd}, 32'd0);
    chk("rst_wbFault", {31'd0, wbFault}, 32'd0);
    chk("rst_length", length, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    exValid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] lens[9];

  initial begin
    bit          ld, st;
    int          kind;
    logic [31:0] addr;
    lens = '{32'd1, 32'd2, 32'd4, 32'd1, 32'd2, 32'd4, 32'd3, 32'd0, 32'd8};
    reset = 1'b1; exValid = 1'b0; exLoad = 1'b0; exStore = 1'b0; exUnsigned = 1'b0;
    exAddress = 32'd0; exData = 32'd0; exLength = 32'd0; exRd = 5'd0;
    dataReadOut = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    finish_reset();

    // Aligned word load.
    issue(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'd4, 5'd5, 32'hDEADBEEF, -1);
    // Byte store.
    issue(1'b0, 1'b1, 1'b0, 32'h103, 32'hAB, 32'd1, 5'd9, 32'h0, -1);
    idle(2);
    // Faults.
    issue(1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 32'd2, 5'd3, 32'h0, -1);
    issue(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'd4, 5'd4, 32'h0, -1);
    issue(1'b0, 1'b1, 1'b0, 32'h100, 32'h55, 32'd3, 5'd6, 32'h0, -1);
    issue(1'b1, 1'b1, 1'b0, 32'h100, 32'h77, 32'd4, 5'd8, 32'h0, -1);
    idle(2);
    // Back-to-back: load followed immediately by a pass-through.
    issue(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'd2, 5'd2, 32'h0000CAFE, -1);
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h1234, 32'd4, 5'd7, 32'h0, -1);
    idle(2);
    // Reset in the second LOAD cycle, then a normal load.
    issue(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'd4, 5'd10, 32'h11112222, 1);
    finish_reset();
    issue(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'd4, 5'd11, 32'h33334444, -1);
    idle(1);

    // Random operations.
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      ld = (kind <= 3) || (kind == 8);
      st = (kind >= 4 && kind <= 6) || (kind == 8);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr = addr & 32'hFFFF_FFFC;
      issue(ld, st, 1'($urandom), addr, $urandom, lens[$urandom_range(0, 8)],
            5'($urandom), $urandom, -1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    chk("wb_queue_empty", 32'(sb.size()), 32'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
